// File: rtl/memory_bus_pkg.sv
// Shared definitions for the 6502 memory bus front-end: address regions,
// IO register offsets and the transaction sequencer states.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'b00,
        REGION_IO       = 2'b01,
        REGION_UNMAPPED = 2'b10,
        REGION_ROM      = 2'b11
    } region_t;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WRITE        = 2'b01,
        READ_ISSUE   = 2'b10,
        READ_CAPTURE = 2'b11
    } state_t;

    localparam logic [3:0] IO_LEDS    = 4'd0;
    localparam logic [3:0] IO_BUTTONS = 4'd1;
    localparam logic [3:0] IO_TICK    = 4'd2;

    // The top two CPU address bits select the region directly.
    function automatic region_t decode_region(input logic [15:0] address);
        return region_t'(address[15:14]);
    endfunction

endpackage

// File: rtl/memory_bus_io_sync.sv
// Two-flop synchronizer that brings asynchronous inputs into the clk domain.
module io_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/memory_bus.sv
// Bus front-end for the 6502 core: decodes RAM/IO/ROM, sequences the
// one-cycle registered memory latency and returns data with a ready pulse.
module memory_bus
    import memory_bus_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 6,
    parameter int          ROM_ADDR_WIDTH = 12,
    parameter logic [7:0]  UNMAPPED_VALUE = 8'hff
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               bus_address,
    input  logic [7:0]                bus_data_in,
    input  logic                      bus_read,
    input  logic                      bus_write,
    output logic [7:0]                bus_data_out,
    output logic                      bus_ready,
    output logic                      bus_busy,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]                ram_data_in,
    input  logic [7:0]                ram_data_out,
    output logic                      ram_write_enable,
    output logic [ROM_ADDR_WIDTH-1:0] rom_address,
    input  logic [7:0]                rom_data,
    output logic [7:0]                leds,
    input  logic [3:0]                buttons
);

    state_t      state;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  tick;
    logic [3:0]  buttons_sync;
    region_t     region_q;
    logic [3:0]  offset_q;
    logic [7:0]  io_value;
    logic [7:0]  read_value;
    logic        unused_addr_bits;

    io_sync #(.WIDTH(4)) u_button_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (buttons),
        .sync_out (buttons_sync)
    );

    // Memory addresses come from the latched transaction address only, so the
    // CPU may change bus_address freely once the strobe has been accepted.
    assign ram_address      = addr_q[RAM_ADDR_WIDTH-1:0];
    assign rom_address      = addr_q[ROM_ADDR_WIDTH-1:0];
    assign ram_data_in      = data_q;
    assign bus_busy         = (state != IDLE);
    assign region_q         = decode_region(addr_q);
    assign offset_q         = addr_q[3:0];
    assign unused_addr_bits = ^addr_q;

    always_comb begin
        io_value = UNMAPPED_VALUE;
        case (offset_q)
            IO_LEDS:    io_value = leds;
            IO_BUTTONS: io_value = {4'b0000, buttons_sync};
            IO_TICK:    io_value = tick;
            default:    io_value = UNMAPPED_VALUE;
        endcase
    end

    always_comb begin
        read_value = UNMAPPED_VALUE;
        case (region_q)
            REGION_RAM:      read_value = ram_data_out;
            REGION_IO:       read_value = io_value;
            REGION_ROM:      read_value = rom_data;
            REGION_UNMAPPED: read_value = UNMAPPED_VALUE;
            default:         read_value = UNMAPPED_VALUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= 8'h00;
        end else begin
            tick <= tick + 8'h01;
        end
    end

    // Write enable is raised on acceptance so it is high for exactly the WRITE
    // cycle; the RAM captures the write on the edge that leaves WRITE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            addr_q           <= 16'h0000;
            data_q           <= 8'h00;
            bus_ready        <= 1'b0;
            bus_data_out     <= 8'h00;
            ram_write_enable <= 1'b0;
            leds             <= 8'h00;
        end else begin
            bus_ready        <= 1'b0;
            ram_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_write) begin
                        addr_q           <= bus_address;
                        data_q           <= bus_data_in;
                        ram_write_enable <= (decode_region(bus_address) == REGION_RAM);
                        state            <= WRITE;
                    end else if (bus_read) begin
                        addr_q <= bus_address;
                        state  <= READ_ISSUE;
                    end
                end
                WRITE: begin
                    if (region_q == REGION_IO && offset_q == IO_LEDS) begin
                        leds <= data_q;
                    end
                    bus_ready <= 1'b1;
                    state     <= IDLE;
                end
                READ_ISSUE: begin
                    state <= READ_CAPTURE;
                end
                READ_CAPTURE: begin
                    bus_data_out <= read_value;
                    bus_ready    <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus.sv
// Self-checking bench for memory_bus with behavioural RAM/ROM and a reference
// model of the memory map, driven by directed and randomized transactions.
module tb_memory_bus;

    logic        clk;
    logic        reset;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_in;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic        bus_ready;
    logic        bus_busy;
    logic [5:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;
    logic [11:0] rom_address;
    logic [7:0]  rom_data;
    logic [7:0]  leds;
    logic [3:0]  buttons;

    int total;
    int bad;

    logic [7:0] ram_mem [64];
    logic [7:0] rom_mem [4096];
    logic [7:0] ram_ref [64];
    logic [7:0] leds_ref;

    memory_bus #(
        .RAM_ADDR_WIDTH (6),
        .ROM_ADDR_WIDTH (12),
        .UNMAPPED_VALUE (8'hff)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_data_in      (bus_data_in),
        .bus_read         (bus_read),
        .bus_write        (bus_write),
        .bus_data_out     (bus_data_out),
        .bus_ready        (bus_ready),
        .bus_busy         (bus_busy),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .ram_write_enable (ram_write_enable),
        .rom_address      (rom_address),
        .rom_data         (rom_data),
        .leds             (leds),
        .buttons          (buttons)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous block RAM / ROM with one clock of read latency.
    always @(posedge clk) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
        rom_data     <= rom_mem[rom_address];
    end

    function automatic logic [7:0] expect_read(input logic [15:0] a);
        int addr;
        addr = int'(a);
        case (addr / 16384)
            0: return ram_ref[addr % 64];
            1: begin
                if (addr % 16 == 0) return leds_ref;
                if (addr % 16 == 1) return {4'b0000, buttons};
                return 8'hff;
            end
            2: return 8'hff;
            default: return rom_mem[addr % 4096];
        endcase
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
        int addr;
        addr = int'(a);
        if (addr / 16384 == 0) ram_ref[addr % 64] = d;
        if (addr / 16384 == 1 && addr % 16 == 0) leds_ref = d;
    endfunction

    // Issues one strobe and watches six cycles after acceptance; optionally
    // fires a stray read+write strobe at window cycle extra_at.
    task automatic bus_op(input logic wr, input logic rd, input logic [15:0] a,
                          input logic [7:0] d, input int extra_at,
                          output int lat, output logic [7:0] rdata,
                          output int we_cycles, output int readies, output logic busy_first);
        @(negedge clk);
        bus_address = a;
        bus_data_in = d;
        bus_write   = wr;
        bus_read    = rd;
        @(negedge clk);
        bus_write  = 1'b0;
        bus_read   = 1'b0;
        lat        = -1;
        rdata      = 8'h00;
        we_cycles  = 0;
        readies    = 0;
        busy_first = bus_busy;
        for (int k = 0; k < 6; k++) begin
            if (ram_write_enable) we_cycles++;
            if (bus_ready) begin
                readies++;
                if (lat < 0) begin
                    lat   = k;
                    rdata = bus_data_out;
                end
            end
            bus_read  = (k == extra_at);
            bus_write = (k == extra_at);
            if (k == extra_at) begin
                bus_address = 16'h0000;
                bus_data_in = 8'hee;
            end
            @(negedge clk);
        end
        bus_read  = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic test_reset();
        total += 7;
        if (bus_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", bus_ready); end
        if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus_busy); end
        if (bus_data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", bus_data_out); end
        if (ram_write_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", ram_write_enable); end
        if (leds !== 8'h00) begin bad++; $display("[TB] FAIL reset_leds got=%h want=00", leds); end
        if (ram_address !== 6'h00) begin bad++; $display("[TB] FAIL reset_ram_addr got=%h want=00", ram_address); end
        if (rom_address !== 12'h000) begin bad++; $display("[TB] FAIL reset_rom_addr got=%h want=000", rom_address); end
    endtask

    task automatic test_ram();
        int lat, we, rdy; logic [7:0] rd; logic busy;
        bus_op(1'b1, 1'b0, 16'h0012, 8'h5a, -1, lat, rd, we, rdy, busy);
        model_write(16'h0012, 8'h5a);
        total += 4;
        if (lat !== 1) begin bad++; $display("[TB] FAIL ram_write_latency got=%0d want=1", lat); end
        if (we !== 1) begin bad++; $display("[TB] FAIL ram_write_we_cycles got=%0d want=1", we); end
        if (rdy !== 1) begin bad++; $display("[TB] FAIL ram_write_readies got=%0d want=1", rdy); end
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ram_write_busy got=%b want=1", busy); end
        bus_op(1'b0, 1'b1, 16'h0012, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 4;
        if (lat !== 2) begin bad++; $display("[TB] FAIL ram_read_latency got=%0d want=2", lat); end
        if (rd !== expect_read(16'h0012)) begin bad++; $display("[TB] FAIL ram_read_data got=%h want=%h", rd, expect_read(16'h0012)); end
        if (rdy !== 1) begin bad++; $display("[TB] FAIL ram_read_readies got=%0d want=1", rdy); end
        if (we !== 0) begin bad++; $display("[TB] FAIL ram_read_we got=%0d want=0", we); end
        bus_op(1'b1, 1'b0, 16'h0052, 8'h33, -1, lat, rd, we, rdy, busy);
        model_write(16'h0052, 8'h33);
        bus_op(1'b0, 1'b1, 16'h0012, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== expect_read(16'h0012)) begin bad++; $display("[TB] FAIL ram_mirror got=%h want=%h", rd, expect_read(16'h0012)); end
    endtask

    task automatic test_io();
        int lat, we, rdy; logic [7:0] rd, t1, t2; logic busy;
        bus_op(1'b1, 1'b0, 16'h4000, 8'ha5, -1, lat, rd, we, rdy, busy);
        model_write(16'h4000, 8'ha5);
        total += 3;
        if (leds !== leds_ref) begin bad++; $display("[TB] FAIL io_leds got=%h want=%h", leds, leds_ref); end
        if (we !== 0) begin bad++; $display("[TB] FAIL io_write_we got=%0d want=0", we); end
        if (lat !== 1) begin bad++; $display("[TB] FAIL io_write_latency got=%0d want=1", lat); end
        buttons = 4'b1010;
        repeat (3) @(negedge clk);
        bus_op(1'b0, 1'b1, 16'h4001, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== expect_read(16'h4001)) begin bad++; $display("[TB] FAIL io_buttons got=%h want=%h", rd, expect_read(16'h4001)); end
        bus_op(1'b0, 1'b1, 16'h400f, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 2;
        if (rd !== 8'hff) begin bad++; $display("[TB] FAIL io_unmapped got=%h want=ff", rd); end
        if (lat !== 2) begin bad++; $display("[TB] FAIL io_read_latency got=%0d want=2", lat); end
        // Consecutive bus_op calls start exactly 8 clocks apart.
        bus_op(1'b0, 1'b1, 16'h4002, 8'h00, -1, lat, t1, we, rdy, busy);
        bus_op(1'b0, 1'b1, 16'h4002, 8'h00, -1, lat, t2, we, rdy, busy);
        total += 1;
        if (8'(t2 - t1) !== 8'd8) begin bad++; $display("[TB] FAIL io_tick_delta got=%0d want=8", 8'(t2 - t1)); end
    endtask

    task automatic test_rom_unmapped();
        int lat, we, rdy; logic [7:0] rd; logic busy;
        bus_op(1'b0, 1'b1, 16'hf123, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 2;
        if (rd !== 8'h77) begin bad++; $display("[TB] FAIL rom_read got=%h want=77", rd); end
        if (lat !== 2) begin bad++; $display("[TB] FAIL rom_latency got=%0d want=2", lat); end
        bus_op(1'b1, 1'b0, 16'hc000, 8'h12, -1, lat, rd, we, rdy, busy);
        total += 4;
        if (lat !== 1) begin bad++; $display("[TB] FAIL rom_write_latency got=%0d want=1", lat); end
        if (we !== 0) begin bad++; $display("[TB] FAIL rom_write_we got=%0d want=0", we); end
        if (rdy !== 1) begin bad++; $display("[TB] FAIL rom_write_readies got=%0d want=1", rdy); end
        if (leds !== leds_ref) begin bad++; $display("[TB] FAIL rom_write_leds got=%h want=%h", leds, leds_ref); end
        bus_op(1'b0, 1'b1, 16'hc000, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== expect_read(16'hc000)) begin bad++; $display("[TB] FAIL rom_unchanged got=%h want=%h", rd, expect_read(16'hc000)); end
        bus_op(1'b0, 1'b1, 16'h8000, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== 8'hff) begin bad++; $display("[TB] FAIL unmapped_read got=%h want=ff", rd); end
        bus_op(1'b1, 1'b0, 16'h8000, 8'h44, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (we !== 0) begin bad++; $display("[TB] FAIL unmapped_write_we got=%0d want=0", we); end
    endtask

    task automatic test_collision();
        int lat, we, rdy; logic [7:0] rd; logic busy;
        bus_op(1'b1, 1'b1, 16'h0020, 8'h9c, -1, lat, rd, we, rdy, busy);
        model_write(16'h0020, 8'h9c);
        total += 3;
        if (rdy !== 1) begin bad++; $display("[TB] FAIL collision_readies got=%0d want=1", rdy); end
        if (lat !== 1) begin bad++; $display("[TB] FAIL collision_latency got=%0d want=1", lat); end
        if (we !== 1) begin bad++; $display("[TB] FAIL collision_we got=%0d want=1", we); end
        bus_op(1'b0, 1'b1, 16'h0020, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== expect_read(16'h0020)) begin bad++; $display("[TB] FAIL collision_readback got=%h want=%h", rd, expect_read(16'h0020)); end
    endtask

    task automatic test_busy_strobe();
        int lat, we, rdy; logic [7:0] rd; logic busy;
        bus_op(1'b1, 1'b0, 16'h0007, 8'h61, 0, lat, rd, we, rdy, busy);
        model_write(16'h0007, 8'h61);
        total += 2;
        if (rdy !== 1) begin bad++; $display("[TB] FAIL busy_write_readies got=%0d want=1", rdy); end
        if (we !== 1) begin bad++; $display("[TB] FAIL busy_write_we got=%0d want=1", we); end
        bus_op(1'b0, 1'b1, 16'h0007, 8'h00, 1, lat, rd, we, rdy, busy);
        total += 3;
        if (rdy !== 1) begin bad++; $display("[TB] FAIL busy_read_readies got=%0d want=1", rdy); end
        if (rd !== expect_read(16'h0007)) begin bad++; $display("[TB] FAIL busy_read_data got=%h want=%h", rd, expect_read(16'h0007)); end
        if (we !== 0) begin bad++; $display("[TB] FAIL busy_read_we got=%0d want=0", we); end
        bus_op(1'b0, 1'b1, 16'h0000, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 1;
        if (rd !== expect_read(16'h0000)) begin bad++; $display("[TB] FAIL busy_stray_write got=%h want=%h", rd, expect_read(16'h0000)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int ready_at [$];
        logic [7:0] data_at_read;
        d = 8'($urandom);
        data_at_read = 8'h00;
        @(negedge clk);
        bus_address = 16'h0031; bus_data_in = d; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        model_write(16'h0031, d);
        for (int k = 0; k < 7; k++) begin
            if (bus_ready) begin
                ready_at.push_back(k);
                if (k == 4) data_at_read = bus_data_out;
            end
            bus_read = (k == 1);
            if (k == 1) bus_address = 16'h0031;
            @(negedge clk);
        end
        bus_read = 1'b0;
        total += 2;
        if (ready_at.size() !== 2 || ready_at[0] !== 1 || ready_at[1] !== 4) begin
            bad++; $display("[TB] FAIL b2b_ready_pattern got=%p want='{1,4}", ready_at);
        end
        if (data_at_read !== expect_read(16'h0031)) begin bad++; $display("[TB] FAIL b2b_data got=%h want=%h", data_at_read, expect_read(16'h0031)); end
    endtask

    task automatic test_random();
        int lat, we, rdy; logic [7:0] rd, exp; logic busy;
        logic [1:0] region; logic [13:0] low; logic [15:0] a; logic [7:0] d; logic is_write;
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 5) begin
                buttons = 4'($urandom);
                repeat (3) @(negedge clk);
            end
            region = 2'($urandom_range(0, 3));
            low    = 14'($urandom);
            if (region == 2'b01 && low[3:0] == 4'd2) low[3:0] = 4'd3;
            a        = {region, low};
            d        = 8'($urandom);
            is_write = 1'($urandom);
            if (is_write) begin
                bus_op(1'b1, 1'b0, a, d, -1, lat, rd, we, rdy, busy);
                model_write(a, d);
                total += 3;
                if (lat !== 1) begin bad++; $display("[TB] FAIL rand_write_latency addr=%h got=%0d want=1", a, lat); end
                if (rdy !== 1) begin bad++; $display("[TB] FAIL rand_write_readies addr=%h got=%0d want=1", a, rdy); end
                if (we !== ((region == 2'b00) ? 1 : 0)) begin bad++; $display("[TB] FAIL rand_write_we addr=%h got=%0d", a, we); end
            end else begin
                exp = expect_read(a);
                bus_op(1'b0, 1'b1, a, 8'h00, -1, lat, rd, we, rdy, busy);
                total += 2;
                if (lat !== 2) begin bad++; $display("[TB] FAIL rand_read_latency addr=%h got=%0d want=2", a, lat); end
                if (rd !== exp) begin bad++; $display("[TB] FAIL rand_read_data addr=%h got=%h want=%h", a, rd, exp); end
            end
        end
        total += 1;
        if (leds !== leds_ref) begin bad++; $display("[TB] FAIL rand_leds got=%h want=%h", leds, leds_ref); end
    endtask

    task automatic test_reset_midflight();
        int lat, we, rdy, seen; logic [7:0] rd; logic busy;
        @(negedge clk);
        bus_address = 16'h0012; bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0;
        #2 reset = 1'b0;
        leds_ref = 8'h00;
        #1;
        total += 6;
        if (bus_ready !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ready got=%b want=0", bus_ready); end
        if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b want=0", bus_busy); end
        if (bus_data_out !== 8'h00) begin bad++; $display("[TB] FAIL midreset_data got=%h want=00", bus_data_out); end
        if (ram_write_enable !== 1'b0) begin bad++; $display("[TB] FAIL midreset_we got=%b want=0", ram_write_enable); end
        if (leds !== 8'h00) begin bad++; $display("[TB] FAIL midreset_leds got=%h want=00", leds); end
        if (ram_address !== 6'h00) begin bad++; $display("[TB] FAIL midreset_ram_addr got=%h want=00", ram_address); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_ready) seen++;
        end
        total += 1;
        if (seen !== 0) begin bad++; $display("[TB] FAIL midreset_no_ready got=%0d want=0", seen); end
        bus_op(1'b0, 1'b1, 16'h0012, 8'h00, -1, lat, rd, we, rdy, busy);
        total += 2;
        if (lat !== 2) begin bad++; $display("[TB] FAIL postreset_latency got=%0d want=2", lat); end
        if (rd !== expect_read(16'h0012)) begin bad++; $display("[TB] FAIL postreset_data got=%h want=%h", rd, expect_read(16'h0012)); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 8'h00;
            ram_ref[i] = 8'h00;
        end
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'((i * 7 + 3) ^ (i / 16));
        rom_mem[12'h123] = 8'h77;
        leds_ref    = 8'h00;
        reset       = 1'b0;
        bus_address = 16'h0000;
        bus_data_in = 8'h00;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        buttons     = 4'b0000;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_ram();
        test_io();
        test_rom_unmapped();
        test_collision();
        test_busy_strobe();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
